// File: rtl/ibex_if_instr_queue_pkg.sv
// Shared types for the IF-stage instruction queue: default depth and the
// per-entry payload captured from the instruction cache.
package ibex_if_instr_queue_pkg;

   localparam int unsigned IF_QUEUE_DEPTH = 2;

   typedef struct packed {
      logic [31:0] rdata;
      logic [31:0] addr;
      logic        err;
      logic        err_plus2;
   } if_q_entry_t;

   // RV32C: any encoding whose low two bits are not 2'b11 is a 16-bit instruction
   function automatic logic is_compressed(input logic [31:0] instr);
      return instr[1:0] != 2'b11;
   endfunction

endpackage

// File: rtl/ibex_if_instr_queue.sv
// Decoupling queue between the instruction cache and ID. in_ready_o comes from
// registered occupancy only, so ID's ready never reaches the cache combinationally.
// The head entry is decoded for compressed format and error qualifiers on the way out.
module ibex_if_instr_queue
   import ibex_if_instr_queue_pkg::*;
#(
   parameter int unsigned Depth    = IF_QUEUE_DEPTH,
   parameter bit          ResetAll = 1'b0
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_i,
   input  logic                       in_valid_i,
   output logic                       in_ready_o,
   input  logic [31:0]                in_rdata_i,
   input  logic [31:0]                in_addr_i,
   input  logic                       in_err_i,
   input  logic                       in_err_plus2_i,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic [31:0]                out_instr_o,
   output logic [31:0]                out_addr_o,
   output logic                       out_is_compressed_o,
   output logic                       out_err_o,
   output logic                       out_err_plus2_o,
   output logic [$clog2(Depth+1)-1:0] occupancy_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = $clog2(Depth + 1);

   if_q_entry_t         mem [Depth];
   if_q_entry_t         head;
   if_q_entry_t         in_entry;
   logic [PtrW-1:0]     wr_ptr, rd_ptr;
   logic [CntW-1:0]     count;
   logic                push, pop;
   logic                head_comp;

   assign in_entry = '{rdata: in_rdata_i, addr: in_addr_i,
                       err: in_err_i, err_plus2: in_err_plus2_i};

   assign in_ready_o  = (count != CntW'(Depth));
   assign out_valid_o = (count != '0) & ~flush_i;
   assign push        = in_valid_i & in_ready_o & ~flush_i;
   assign pop         = out_valid_o & out_ready_i;
   assign occupancy_o = count;

   // Control state: pointers wrap by explicit compare so non-power-of-2 depths work
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= (wr_ptr == PtrW'(Depth - 1)) ? '0 : wr_ptr + PtrW'(1);
         if (pop)  rd_ptr <= (rd_ptr == PtrW'(Depth - 1)) ? '0 : rd_ptr + PtrW'(1);
         case ({push, pop})
            2'b10:   count <= count + CntW'(1);
            2'b01:   count <= count - CntW'(1);
            default: count <= count;
         endcase
      end
   end

   // Payload storage; cleared on reset only when ResetAll, otherwise flop-only (no reset)
   always_ff @(posedge clk_i) begin
      if (ResetAll && rst_i) begin
         for (int i = 0; i < int'(Depth); i++) mem[i] <= '0;
      end else if (push) begin
         mem[wr_ptr] <= in_entry;
      end
   end

   // Head decode: compressed instructions present with upper halfword zeroed
   always_comb begin
      head                = mem[rd_ptr];
      head_comp           = is_compressed(head.rdata);
      out_instr_o         = head_comp ? {16'h0, head.rdata[15:0]} : head.rdata;
      out_addr_o          = head.addr;
      out_is_compressed_o = head_comp;
      out_err_o           = head.err;
      out_err_plus2_o     = head.err & head.err_plus2 & ~head_comp;
   end

   // Protocol and occupancy invariants
   a_addr_aligned: assert property (@(posedge clk_i) disable iff (rst_i)
      push |-> !in_addr_i[0]);
   a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
      pop |-> (count != '0));
   a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
      count <= CntW'(Depth));
   a_in_stable: assert property (@(posedge clk_i) disable iff (rst_i)
      (in_valid_i && !in_ready_o && !flush_i) |=>
      (flush_i || (in_valid_i && $stable(in_rdata_i) && $stable(in_addr_i) &&
                   $stable(in_err_i) && $stable(in_err_plus2_i))));

endmodule

// File: tb/tb_ibex_if_instr_queue.sv
// Self-checking bench for ibex_if_instr_queue: directed scenarios plus randomized
// traffic compared against a queue-based reference model of the FIFO contract.
module tb_ibex_if_instr_queue;
   import ibex_if_instr_queue_pkg::*;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst_i = 1'b0, flush_i = 1'b0;
   logic        in_valid_i = 1'b0, in_ready_o;
   logic [31:0] in_rdata_i = '0, in_addr_i = '0;
   logic        in_err_i = 1'b0, in_err_plus2_i = 1'b0;
   logic        out_valid_o, out_ready_i = 1'b0;
   logic [31:0] out_instr_o, out_addr_o;
   logic        out_is_compressed_o, out_err_o, out_err_plus2_o;
   logic [1:0]  occupancy_o;

   int n_pass = 0, n_total = 0;
   if_q_entry_t mq[$];
   bit last_push, last_flush;

   ibex_if_instr_queue #(.Depth(DEPTH), .ResetAll(1'b0)) dut (
      .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .in_rdata_i(in_rdata_i), .in_addr_i(in_addr_i),
      .in_err_i(in_err_i), .in_err_plus2_i(in_err_plus2_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .out_instr_o(out_instr_o), .out_addr_o(out_addr_o),
      .out_is_compressed_o(out_is_compressed_o),
      .out_err_o(out_err_o), .out_err_plus2_o(out_err_plus2_o),
      .occupancy_o(occupancy_o));

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_instr(input logic [31:0] r);
      return (r[1:0] == 2'b11) ? r : {16'h0000, r[15:0]};
   endfunction

   // Advance one clock and apply the queue contract to the reference model
   task automatic tick();
      bit rdy, psh, pp;
      if_q_entry_t e;
      e   = '{rdata: in_rdata_i, addr: in_addr_i, err: in_err_i, err_plus2: in_err_plus2_i};
      rdy = (mq.size() < DEPTH);
      psh = in_valid_i && rdy && !flush_i;
      pp  = (mq.size() != 0) && !flush_i && out_ready_i;
      @(posedge clk);
      if (rst_i || flush_i) mq.delete();
      else begin
         if (pp) void'(mq.pop_front());
         if (psh) mq.push_back(e);
      end
      last_push  = psh && !rst_i;
      last_flush = flush_i || rst_i;
      #1;
   endtask

   task automatic drive_in(input logic v, input logic [31:0] d, input logic [31:0] a,
                           input logic er, input logic p2);
      in_valid_i = v; in_rdata_i = d; in_addr_i = a; in_err_i = er; in_err_plus2_i = p2;
   endtask

   task automatic test_reset();
      rst_i = 1'b1; tick(); tick(); rst_i = 1'b0; #1;
      n_total++; if (out_valid_o !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid_o); else n_pass++;
      n_total++; if (in_ready_o !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready_o); else n_pass++;
      n_total++; if (occupancy_o !== 2'd0) $display("FAIL reset_occupancy got %0d exp 0", occupancy_o); else n_pass++;
   endtask

   task automatic test_fill_drain();
      out_ready_i = 1'b0;
      drive_in(1'b1, 32'h0000_0013, 32'h100, 1'b0, 1'b0); tick();
      n_total++; if (occupancy_o !== 2'd1) $display("FAIL fill_occ1 got %0d exp 1", occupancy_o); else n_pass++;
      n_total++; if (out_valid_o !== 1'b1) $display("FAIL fill_valid got %b exp 1", out_valid_o); else n_pass++;
      drive_in(1'b1, 32'h0041_0093, 32'h104, 1'b0, 1'b0); tick();
      drive_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0); #1;
      n_total++; if (occupancy_o !== 2'd2) $display("FAIL fill_occ2 got %0d exp 2", occupancy_o); else n_pass++;
      n_total++; if (in_ready_o !== 1'b0) $display("FAIL full_in_ready got %b exp 0", in_ready_o); else n_pass++;
      out_ready_i = 1'b1; #1;
      n_total++; if (out_instr_o !== 32'h0000_0013 || out_addr_o !== 32'h100)
         $display("FAIL drain_head0 got %h@%h exp 00000013@00000100", out_instr_o, out_addr_o); else n_pass++;
      tick();
      n_total++; if (occupancy_o !== 2'd1) $display("FAIL drain_occ1 got %0d exp 1", occupancy_o); else n_pass++;
      n_total++; if (out_instr_o !== 32'h0041_0093 || out_addr_o !== 32'h104)
         $display("FAIL drain_head1 got %h@%h exp 00410093@00000104", out_instr_o, out_addr_o); else n_pass++;
      tick();
      n_total++; if (occupancy_o !== 2'd0 || out_valid_o !== 1'b0)
         $display("FAIL drain_empty got occ=%0d v=%b exp occ=0 v=0", occupancy_o, out_valid_o); else n_pass++;
   endtask

   task automatic test_compressed();
      out_ready_i = 1'b0;
      drive_in(1'b1, 32'hDEAD_4501, 32'h200, 1'b0, 1'b0); tick();
      drive_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0); #1;
      n_total++; if (out_is_compressed_o !== 1'b1) $display("FAIL comp_flag got %b exp 1", out_is_compressed_o); else n_pass++;
      n_total++; if (out_instr_o !== 32'h0000_4501) $display("FAIL comp_instr got %h exp 00004501", out_instr_o); else n_pass++;
      out_ready_i = 1'b1; tick(); out_ready_i = 1'b0;
      drive_in(1'b1, 32'h1234_5003, 32'h202, 1'b0, 1'b0); tick();
      drive_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0); #1;
      n_total++; if (out_is_compressed_o !== 1'b0) $display("FAIL uncomp_flag got %b exp 0", out_is_compressed_o); else n_pass++;
      n_total++; if (out_instr_o !== 32'h1234_5003) $display("FAIL uncomp_instr got %h exp 12345003", out_instr_o); else n_pass++;
      out_ready_i = 1'b1; tick(); out_ready_i = 1'b0;
   endtask

   task automatic test_flush();
      out_ready_i = 1'b0;
      drive_in(1'b1, 32'h0000_0013, 32'h300, 1'b0, 1'b0); tick();
      drive_in(1'b1, 32'h0000_0033, 32'h304, 1'b0, 1'b0); tick();
      drive_in(1'b1, 32'h0000_0073, 32'h308, 1'b0, 1'b0);
      flush_i = 1'b1; out_ready_i = 1'b1; #1;
      n_total++; if (out_valid_o !== 1'b0) $display("FAIL flush_cycle_valid got %b exp 0", out_valid_o); else n_pass++;
      tick(); flush_i = 1'b0; drive_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0); #1;
      n_total++; if (occupancy_o !== 2'd0 || out_valid_o !== 1'b0)
         $display("FAIL flush_full got occ=%0d v=%b exp occ=0 v=0", occupancy_o, out_valid_o); else n_pass++;
      // partially full: the push offered during the flush cycle must be dropped
      out_ready_i = 1'b0;
      drive_in(1'b1, 32'h0000_0013, 32'h310, 1'b0, 1'b0); tick();
      drive_in(1'b1, 32'h0000_0093, 32'h314, 1'b0, 1'b0); flush_i = 1'b1; tick();
      flush_i = 1'b0; drive_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0); #1;
      n_total++; if (occupancy_o !== 2'd0 || in_ready_o !== 1'b1)
         $display("FAIL flush_drop_push got occ=%0d rdy=%b exp occ=0 rdy=1", occupancy_o, in_ready_o); else n_pass++;
   endtask

   task automatic test_errors();
      out_ready_i = 1'b0;
      drive_in(1'b1, 32'h0000_4501, 32'h400, 1'b1, 1'b1); tick();
      drive_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0); #1;
      n_total++; if (out_err_o !== 1'b1 || out_err_plus2_o !== 1'b0)
         $display("FAIL err_comp got err=%b p2=%b exp err=1 p2=0", out_err_o, out_err_plus2_o); else n_pass++;
      out_ready_i = 1'b1; tick(); out_ready_i = 1'b0;
      drive_in(1'b1, 32'h0000_0013, 32'h402, 1'b1, 1'b1); tick();
      drive_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0); #1;
      n_total++; if (out_err_o !== 1'b1 || out_err_plus2_o !== 1'b1)
         $display("FAIL err_uncomp got err=%b p2=%b exp err=1 p2=1", out_err_o, out_err_plus2_o); else n_pass++;
      out_ready_i = 1'b1; tick(); out_ready_i = 1'b0;
   endtask

   task automatic test_streaming();
      out_ready_i = 1'b1;
      for (int c = 0; c < 100; c++) begin
         drive_in(1'b1, $urandom, $urandom & 32'hFFFF_FFFE, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
         #1;
         if (c > 0) begin
            n_total++;
            if (occupancy_o !== 2'd1 || out_valid_o !== 1'b1 || mq.size() != 1)
               $display("FAIL stream_occ c=%0d got occ=%0d v=%b exp occ=1 v=1", c, occupancy_o, out_valid_o);
            else if (out_instr_o !== ref_instr(mq[0].rdata) || out_addr_o !== mq[0].addr)
               $display("FAIL stream_head c=%0d got %h@%h exp %h@%h", c, out_instr_o, out_addr_o,
                        ref_instr(mq[0].rdata), mq[0].addr);
            else n_pass++;
         end
         tick();
      end
      drive_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0); tick(); tick();
   endtask

   task automatic test_random();
      bit exp_v, exp_c;
      for (int c = 0; c < 300; c++) begin
         if (!(in_valid_i && !last_push && !last_flush))
            drive_in(1'($urandom_range(0, 9) < 7), $urandom, $urandom & 32'hFFFF_FFFE,
                     1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
         flush_i     = ($urandom_range(0, 19) == 0);
         out_ready_i = 1'($urandom_range(0, 1));
         #1;
         exp_v = (mq.size() != 0) && !flush_i;
         n_total++;
         if (out_valid_o !== exp_v || occupancy_o !== 2'(mq.size()) || in_ready_o !== (mq.size() < DEPTH))
            $display("FAIL rand_ctrl c=%0d got v=%b occ=%0d rdy=%b exp v=%b occ=%0d rdy=%b", c,
                     out_valid_o, occupancy_o, in_ready_o, exp_v, mq.size(), mq.size() < DEPTH);
         else n_pass++;
         if (mq.size() != 0) begin
            exp_c = (mq[0].rdata[1:0] != 2'b11);
            n_total++;
            if (out_instr_o !== ref_instr(mq[0].rdata) || out_addr_o !== mq[0].addr ||
                out_is_compressed_o !== exp_c || out_err_o !== mq[0].err ||
                out_err_plus2_o !== (mq[0].err & mq[0].err_plus2 & ~exp_c))
               $display("FAIL rand_head c=%0d got %h@%h c=%b e=%b p=%b exp %h@%h", c, out_instr_o,
                        out_addr_o, out_is_compressed_o, out_err_o, out_err_plus2_o,
                        ref_instr(mq[0].rdata), mq[0].addr);
            else n_pass++;
         end
         tick();
      end
      flush_i = 1'b1; tick(); flush_i = 1'b0;
      drive_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0); out_ready_i = 1'b0; #1;
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_compressed();
      test_flush();
      test_errors();
      test_streaming();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
